// File: rtl/lzc_normalizer.sv
// ---------------------------------------------------------------------------
// lzc_normalizer
//
// Two-stage valid/ready normalization pipeline. Stage 1 registers the
// operand together with its leading-zero count; stage 2 registers the
// operand left-aligned by that count so that a nonzero result has its
// MSB set. Full throughput, and safe under downstream backpressure.
//
// Parameters
//   N        operand width (N >= 2, need not be a power of two)
//   D_WIDTH  shift/count width, derived as $clog2(N)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, flushes the pipeline
//   in_valid   in_x carries an operand
//   in_ready   the pipeline accepts in_x this cycle
//   in_x       operand to normalize
//   out_valid  out_* carry a result
//   out_ready  consumer accepts out_* this cycle
//   out_z      in_x << lzc(in_x)
//   out_lzc    leading-zero count of in_x (0 when in_x is zero)
//   out_zero   in_x was all zeros
// ---------------------------------------------------------------------------
module lzc_normalizer #(
    parameter  int N       = 32,
    localparam int D_WIDTH = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_z,
    output logic [D_WIDTH-1:0] out_lzc,
    output logic               out_zero
);

    // Priority encoder: the highest set bit wins because it is visited last.
    // An all-zero operand leaves the count at 0.
    function automatic logic [D_WIDTH-1:0] lead_zeros(input logic [N-1:0] x);
        logic [D_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) cnt = D_WIDTH'(N - 1 - i);
        end
        return cnt;
    endfunction

    // Logarithmic barrel shift left; bits pushed past N-1 fall off, which
    // matters only when N is not a power of two.
    function automatic logic [N-1:0] align_left(input logic [N-1:0] x,
                                                input logic [D_WIDTH-1:0] d);
        logic [N-1:0] v;
        v = x;
        for (int k = 0; k < D_WIDTH; k++) begin
            if (d[k]) v = v << (1 << k);
        end
        return v;
    endfunction

    logic               vld_p1;
    logic [N-1:0]       x_p1;
    logic [D_WIDTH-1:0] lzc_p1;
    logic               zero_p1;

    logic               vld_p2;
    logic [N-1:0]       z_p2;
    logic [D_WIDTH-1:0] lzc_p2;
    logic               zero_p2;

    logic               s1_en;
    logic               s2_en;

    // Ready ripples back combinationally from the consumer, so a full
    // pipeline still accepts a new operand in a cycle where it drains.
    assign s2_en    = !vld_p2 || out_ready;
    assign s1_en    = !vld_p1 || s2_en;
    assign in_ready = s1_en;

    // ---- stage 1: operand + leading-zero count ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            x_p1    <= '0;
            lzc_p1  <= '0;
            zero_p1 <= 1'b0;
        end else if (s1_en) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                x_p1    <= in_x;
                lzc_p1  <= lead_zeros(in_x);
                zero_p1 <= (in_x == '0);
            end
        end
    end

    // ---- stage 2: left-aligned operand ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            z_p2    <= '0;
            lzc_p2  <= '0;
            zero_p2 <= 1'b0;
        end else if (s2_en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                z_p2    <= align_left(x_p1, lzc_p1);
                lzc_p2  <= lzc_p1;
                zero_p2 <= zero_p1;
            end
        end
    end

    // ---- outputs straight from stage 2 ----
    assign out_valid = vld_p2;
    assign out_z     = z_p2;
    assign out_lzc   = lzc_p2;
    assign out_zero  = zero_p2;

endmodule
